bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single system bus between the core's instruction-fetch and data ports and decodes
//  the granted address onto one-hot slave selects (rom, uart, clint, tim0, tim1, ram) using the
//  region bounds in package configure. Sits between the core and the slave set.
//  Unmapped accesses and stalled slaves are terminated locally with an error response.
// PARAMETERS
//  timeout_cycles  256  max BUSY cycles without slv_ready before abort (>=2)
//  region bounds   from configure: *_base_addr / *_top_addr for rom,uart,clint,tim0,tim1,ram
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  imem_valid   in   1   fetch request, held with addr stable until imem_ready
//  imem_addr    in   32  fetch address
//  imem_ready   out  1   fetch done pulse (1 cycle)
//  imem_rdata   out  32  fetch data, valid when imem_ready
//  imem_error   out  1   qualifies imem_ready: unmapped or timeout
//  dmem_valid   in   1   data request, held with addr/wdata/wstrb stable until dmem_ready
//  dmem_addr    in   32  data address
//  dmem_wdata   in   32  write data
//  dmem_wstrb   in   4   byte strobes; 0 = read
//  dmem_ready   out  1   data done pulse (1 cycle)
//  dmem_rdata   out  32  read data, valid when dmem_ready
//  dmem_error   out  1   qualifies dmem_ready: unmapped or timeout
//  slv_valid    out  1   registered request to selected slave
//  slv_sel      out  6   one-hot {ram,tim1,tim0,clint,uart,rom} (bit0=rom)
//  slv_instr    out  1   1 = granted requester is fetch port
//  slv_addr     out  32  registered address
//  slv_wdata    out  32  registered write data
//  slv_wstrb    out  4   registered strobes (always 0 for fetch)
//  slv_rdata    in   32  slave read data
//  slv_ready    in   1   slave completion, sampled only while slv_valid=1
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, last_grant=data, all outputs 0, timeout counter 0.
//  Decode: hit if base <= addr < top (unsigned, top exclusive); regions disjoint; no hit = unmapped.
//  States: IDLE, BUSY, ERR.
//  IDLE: no valid -> stay. One valid -> grant it. Both valid -> grant the port NOT in last_grant
//   (round-robin; after reset fetch wins first). On grant: last_grant<=winner, register
//   addr/wdata/wstrb/instr; mapped -> slv_sel<=onehot, slv_valid<=1, BUSY; unmapped -> ERR.
//  BUSY: slv_valid=1. Cycle with slv_ready=1: granted port ready=1, rdata=slv_rdata (comb.),
//   error=0; slv_valid,slv_sel cleared next edge; -> IDLE. Else counter++.
//   Counter reaches timeout_cycles-1 with slv_ready=0: granted ready=1,error=1,rdata=0; -> IDLE.
//  ERR: one cycle; granted ready=1,error=1,rdata=0; -> IDLE. No slave sees the access.
//  Counter cleared on every entry to BUSY.
//  Latency: request at cycle N -> slv_valid at N+1 -> ready earliest N+1 (zero-wait slave).
//   Unmapped: ready at N+1. One IDLE bubble between transactions (no back-to-back grant).
//  Non-granted port's ready/error/rdata stay 0. slv_ready outside BUSY ignored.
//  Requests are not cancellable; a master dropping valid mid-BUSY is illegal (assert in sim).
//  Reset mid-transaction: aborted silently, no ready pulse, state to IDLE.
// TESTING
//  Fetch 0x80000000, slave ready 2 cycles after slv_valid, rdata 0x00000013 -> slv_sel=6'b100000,
//   slv_instr=1, imem_ready 1 cycle with 0x00000013, error=0.
//  Both valid from reset, dmem 0x01000000 wstrb 4'hF -> fetch served first, then dmem with
//   slv_sel=6'b000010 wstrb=4'hF; alternate thereafter over 4 more dual requests.
//  dmem read 0x30000000 (unmapped) -> slv_valid never 1, dmem_ready+dmem_error at N+1, rdata 0.
//  Boundary: addr 0x0000007C -> rom; 0x00000080 -> error; 0x0200BFFC -> clint; 0x8FFFFFFC -> ram.
//  Slave never ready on 0x10000000 -> imem_ready+imem_error exactly timeout_cycles after slv_valid.
//  Assert reset during BUSY -> all outputs 0 immediately, no ready pulse, next request served.

Source files
------------

// File: rtl/bus_arbiter.sv
// Bus arbiter: shares the system bus between the fetch and data ports of the core,
// decodes the granted address onto one-hot slave selects and terminates unmapped
// or stalled accesses locally with an error response.

package configure;
    // Region bounds: base inclusive, top exclusive.
    localparam logic [31:0] rom_base_addr   = 32'h0000_0000;
    localparam logic [31:0] rom_top_addr    = 32'h0000_0080;
    localparam logic [31:0] uart_base_addr  = 32'h0100_0000;
    localparam logic [31:0] uart_top_addr   = 32'h0100_1000;
    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_top_addr  = 32'h0200_C000;
    localparam logic [31:0] tim0_base_addr  = 32'h1000_0000;
    localparam logic [31:0] tim0_top_addr   = 32'h1000_0010;
    localparam logic [31:0] tim1_base_addr  = 32'h1000_1000;
    localparam logic [31:0] tim1_top_addr   = 32'h1000_1010;
    localparam logic [31:0] ram_base_addr   = 32'h8000_0000;
    localparam logic [31:0] ram_top_addr    = 32'h9000_0000;
endpackage

module bus_arbiter #(
    parameter int timeout_cycles = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_error,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic        slv_valid,
    output logic [5:0]  slv_sel,
    output logic        slv_instr,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    input  logic [31:0] slv_rdata,
    input  logic        slv_ready
);

    localparam int              cnt_w    = $clog2(timeout_cycles);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t           state, next_state;
    logic             last_grant_instr;
    logic             win_instr;
    logic [31:0]      win_addr;
    logic [5:0]       win_sel;
    logic             grant;
    logic             done;
    logic             error;
    logic [31:0]      resp_rdata;
    logic [cnt_w-1:0] timeout_count;

    // Single unsigned compare: (addr - base) wraps for addr < base, so one test covers both bounds.
    function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] top);
        return (addr - base) < (top - base);
    endfunction

    function automatic logic [5:0] decode(input logic [31:0] addr);
        return {in_region(addr, configure::ram_base_addr,   configure::ram_top_addr),
                in_region(addr, configure::tim1_base_addr,  configure::tim1_top_addr),
                in_region(addr, configure::tim0_base_addr,  configure::tim0_top_addr),
                in_region(addr, configure::clint_base_addr, configure::clint_top_addr),
                in_region(addr, configure::uart_base_addr,  configure::uart_top_addr),
                in_region(addr, configure::rom_base_addr,   configure::rom_top_addr)};
    endfunction

    // Next-state logic: round-robin grant in IDLE, completion or timeout in BUSY.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        win_instr  = imem_valid && (!dmem_valid || !last_grant_instr);
        win_addr   = win_instr ? imem_addr : dmem_addr;
        win_sel    = decode(win_addr);
        case (state)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    grant      = 1'b1;
                    next_state = (win_sel != '0) ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (slv_ready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (timeout_count == cnt_last) begin
                    done       = 1'b1;
                    error      = 1'b1;
                    next_state = IDLE;
                end
            end
            ERR: begin
                done       = 1'b1;
                error      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Steer the response to the granted port only; the other port stays quiet.
    always_comb begin
        resp_rdata = (done && !error) ? slv_rdata : '0;
        imem_ready = done && slv_instr;
        imem_error = error && slv_instr;
        imem_rdata = slv_instr ? resp_rdata : '0;
        dmem_ready = done && !slv_instr;
        dmem_error = error && !slv_instr;
        dmem_rdata = slv_instr ? '0 : resp_rdata;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Capture the winning request on grant; drop the slave select when the access ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_instr <= 1'b0;
            slv_valid        <= 1'b0;
            slv_sel          <= '0;
            slv_instr        <= 1'b0;
            slv_addr         <= '0;
            slv_wdata        <= '0;
            slv_wstrb        <= '0;
        end else if (grant) begin
            last_grant_instr <= win_instr;
            slv_instr        <= win_instr;
            slv_addr         <= win_addr;
            slv_wdata        <= win_instr ? '0 : dmem_wdata;
            slv_wstrb        <= win_instr ? '0 : dmem_wstrb;
            slv_sel          <= win_sel;
            slv_valid        <= (win_sel != '0);
        end else if (done) begin
            slv_valid        <= 1'b0;
            slv_sel          <= '0;
        end
    end

    // Stall counter: cleared on every grant, counts each BUSY cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              timeout_count <= '0;
        else if (grant)          timeout_count <= '0;
        else if (state == BUSY)  timeout_count <= timeout_count + 1'b1;
    end

    // Requests cannot be withdrawn while they are being served.
    a_request_held: assert property (@(posedge clock) disable iff (!reset)
        (state != IDLE) |-> (slv_instr ? imem_valid : dmem_valid));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus scoreboard queue, with
// hand-written sequences for arbitration, timeout and reset-abort.

module tb_bus_arbiter;

    localparam int TO = 256;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [5:0]  exp_sel;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        instr;
        logic        err;
        logic [31:0] rdata;
        logic [5:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clock, reset;
    logic        imem_valid, imem_ready, imem_error;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_valid, dmem_ready, dmem_error;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        slv_valid, slv_instr, slv_ready;
    logic [5:0]  slv_sel;
    logic [31:0] slv_addr, slv_wdata, slv_rdata;
    logic [3:0]  slv_wstrb;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   slave_delay = 0;
    int   slave_cnt   = 0;
    logic noise       = 1'b0;
    logic slv_valid_q = 1'b0;

    bus_arbiter #(.timeout_cycles(TO)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_error(dmem_error),
        .slv_valid(slv_valid), .slv_sel(slv_sel), .slv_instr(slv_instr),
        .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0013 : {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_master"}, {imem_ready, imem_error, dmem_ready, dmem_error,
                                 imem_rdata | dmem_rdata}, '0);
        check({tag, "_slave"}, {slv_valid, slv_sel, slv_instr, slv_wstrb, slv_addr}, '0);
        check({tag, "_wdata"}, slv_wdata, '0);
    endtask

    // Slave model: ready after slave_delay cycles of slv_valid, garbage rdata otherwise.
    initial begin
        slv_ready = 1'b0;
        slv_rdata = 32'hBAD0_0000;
        forever begin
            @(posedge clock);
            #1;
            if (slv_valid) begin
                slv_ready = (slave_cnt == slave_delay);
                slv_rdata = slv_ready ? slave_data(slv_addr) : (32'hBAD0_0000 | slave_cnt);
                slave_cnt++;
            end else begin
                slave_cnt = 0;
                slv_ready = noise;
                slv_rdata = 32'hBAD0_FFFF;
            end
        end
    end

    // Monitor: slave-side request and master-side response against the scoreboard head.
    always @(negedge clock) begin
        exp_t h;
        check("single_ready", imem_ready & dmem_ready, 1'b0);
        if (!imem_ready) check("imem_quiet", {imem_error, imem_rdata}, '0);
        if (!dmem_ready) check("dmem_quiet", {dmem_error, dmem_rdata}, '0);
        if (slv_valid && !slv_valid_q) begin
            if (exp_q.size() == 0) begin
                check("slv_unexpected", slv_valid, 1'b0);
            end else begin
                h = exp_q[0];
                check("slv_valid_mapped", slv_valid, |h.sel);
                check("slv_sel", slv_sel, h.sel);
                check("slv_instr", slv_instr, h.instr);
                check("slv_addr", slv_addr, h.addr);
                check("slv_wstrb", slv_wstrb, h.wstrb);
                if (!h.instr) check("slv_wdata", slv_wdata, h.wdata);
            end
        end
        slv_valid_q = slv_valid;
        if (imem_ready || dmem_ready) begin
            if (exp_q.size() == 0) begin
                check("ready_unexpected", imem_ready | dmem_ready, 1'b0);
            end else begin
                h = exp_q.pop_front();
                check("resp_port", {imem_ready, dmem_ready}, h.instr ? 2'b10 : 2'b01);
                check("resp_error", h.instr ? imem_error : dmem_error, h.err);
                check("resp_rdata", h.instr ? imem_rdata : dmem_rdata, h.rdata);
            end
        end
    end

    // Wait (bounded) for the port's ready, then release its valid after the edge.
    task automatic wait_done(input logic instr, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(instr ? imem_ready : dmem_ready) && n < budget);
        check(instr ? "imem_ready_seen" : "dmem_ready_seen", instr ? imem_ready : dmem_ready, 1'b1);
        @(posedge clock);
        #1;
        if (instr) imem_valid = 1'b0;
        else       dmem_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        @(posedge clock);
        #1;
        slave_delay = v.delay;
        e = '{instr: v.instr, err: v.exp_err,
              rdata: v.exp_err ? 32'h0 : slave_data(v.addr),
              sel: v.exp_sel, addr: v.addr, wdata: v.wdata,
              wstrb: v.instr ? 4'h0 : v.wstrb};
        exp_q.push_back(e);
        if (v.instr) begin
            imem_addr  = v.addr;
            imem_valid = 1'b1;
        end else begin
            dmem_addr  = v.addr;
            dmem_wdata = v.wdata;
            dmem_wstrb = v.wstrb;
            dmem_valid = 1'b1;
        end
        wait_done(v.instr, 600, n);
        check("latency", n, v.exp_err ? 2 : v.delay + 2);
    endtask

    vec_t vecs[12];

    initial begin
        exp_t ef, ed, e;
        int   n, nv;
        logic w;

        vecs[0]  = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 2, 6'b100000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0100_0000, 32'hCAFE_F00D, 4'hF, 0, 6'b000010, 1'b0};
        vecs[2]  = '{1'b0, 32'h3000_0000, 32'h0,         4'h0, 0, 6'b000000, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_007C, 32'h0,         4'h0, 1, 6'b000001, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0080, 32'h0,         4'h0, 0, 6'b000000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0200_BFFC, 32'h0,         4'h0, 0, 6'b000100, 1'b0};
        vecs[6]  = '{1'b0, 32'h8FFF_FFFC, 32'h5566_7788, 4'h3, 3, 6'b100000, 1'b0};
        vecs[7]  = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 0, 6'b001000, 1'b0};
        vecs[8]  = '{1'b1, 32'h1000_1008, 32'h0,         4'h0, 1, 6'b010000, 1'b0};
        vecs[9]  = '{1'b0, 32'h9000_0000, 32'h0,         4'h0, 0, 6'b000000, 1'b1};
        vecs[10] = '{1'b1, 32'h0200_C000, 32'h0,         4'h0, 0, 6'b000000, 1'b1};
        vecs[11] = '{1'b0, 32'h0100_1000, 32'h1,         4'h1, 0, 6'b000000, 1'b1};

        reset      = 1'b0;
        imem_valid = 1'b0;
        imem_addr  = '0;
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        #3;
        check_idle_outputs("reset");
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("post_reset");

        // Both ports requesting from reset: fetch first, then strict alternation.
        @(posedge clock);
        #1;
        slave_delay = 0;
        ef = '{instr: 1'b1, err: 1'b0, rdata: 32'h0000_0013, sel: 6'b100000,
               addr: 32'h8000_0000, wdata: 32'h0, wstrb: 4'h0};
        ed = '{instr: 1'b0, err: 1'b0, rdata: slave_data(32'h0100_0000), sel: 6'b000010,
               addr: 32'h0100_0000, wdata: 32'h1234_5678, wstrb: 4'hF};
        imem_addr  = ef.addr;
        dmem_addr  = ed.addr;
        dmem_wdata = ed.wdata;
        dmem_wstrb = ed.wstrb;
        exp_q.push_back(ef);
        exp_q.push_back(ed);
        imem_valid = 1'b1;
        dmem_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = (k % 2 == 0);
            wait_done(w, 50, n);
            check("dual_latency", n, 2);
            if (k < 4) begin
                if (w) begin
                    exp_q.push_back(ef);
                    imem_valid = 1'b1;
                end else begin
                    exp_q.push_back(ed);
                    dmem_valid = 1'b1;
                end
            end
        end

        // Single requests with stray slv_ready outside BUSY.
        noise = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Slave that never answers: abort in the TO-th cycle of slv_valid.
        @(posedge clock);
        #1;
        slave_delay = 1_000_000;
        e = '{instr: 1'b1, err: 1'b1, rdata: 32'h0, sel: 6'b001000,
              addr: 32'h1000_0000, wdata: 32'h0, wstrb: 4'h0};
        exp_q.push_back(e);
        imem_addr  = e.addr;
        imem_valid = 1'b1;
        n  = 0;
        nv = 0;
        do begin
            @(negedge clock);
            n++;
            if (slv_valid) nv++;
        end while (!imem_ready && n < 600);
        check("timeout_ready_seen", imem_ready, 1'b1);
        check("timeout_valid_cycles", nv, TO);
        @(posedge clock);
        #1;
        imem_valid = 1'b0;

        // Reset in the middle of a BUSY access: silent abort, then normal service.
        noise = 1'b0;
        @(posedge clock);
        #1;
        e = '{instr: 1'b0, err: 1'b0, rdata: 32'h0, sel: 6'b100000,
              addr: 32'h8000_0010, wdata: 32'hA0A0_B0B0, wstrb: 4'hF};
        exp_q.push_back(e);
        dmem_addr  = e.addr;
        dmem_wdata = e.wdata;
        dmem_wstrb = e.wstrb;
        dmem_valid = 1'b1;
        n = 0;
        while (!slv_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("abort_slv_valid", slv_valid, 1'b1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_q.delete();
        dmem_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_idle_outputs("held_reset");
        #2 reset = 1'b1;
        run_vec('{1'b1, 32'h0000_0010, 32'h0, 4'h0, 0, 6'b000001, 1'b0});

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
